// File: rtl/serial_cmd_engine.sv
// rtl/serial_cmd_engine.sv - serial command engine between a UART byte interface and board control logic
//
// Purpose: decodes one-byte opcodes followed by a fixed number of argument
// bytes, drives registered control outputs, replies to VERSION and STATUS,
// and snapshots and streams the histogram words on SEND_HISTOGRAM.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rxReady, rxData            received byte strobe and data
//   txBusy                     UART transmitter busy
//   txStart, txData            transmit strobe and byte
//   h_in                       NUM_HIST histogram words, channel k at [k*HIST_W +: HIST_W]
//   resethist                  one-cycle pulse when the histogram is snapshotted
//   disable_line_drivers,
//   enable_debug_outputs,
//   passthrough, vetopmtlast,
//   useInternalTestPulse,
//   useExternalTestPulse       control outputs
//   pll_shifts, updatepll      PLL phase-shift bytes and update pulse
//   cmd_error                  sticky bad-opcode / argument-timeout flag
//   busy                       high whenever the engine is not idle
module serial_cmd_engine #(
  parameter int         NUM_HIST    = 10,
  parameter int         HIST_W      = 32,
  parameter int         NUM_PLL     = 6,
  parameter logic [7:0] FW_VERSION  = 8'd24,
  parameter int         ARG_TIMEOUT = 50000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rxReady,
  input  logic [7:0]                 rxData,
  input  logic                       txBusy,
  output logic                       txStart,
  output logic [7:0]                 txData,
  input  logic [NUM_HIST*HIST_W-1:0] h_in,
  output logic                       resethist,
  output logic                       disable_line_drivers,
  output logic                       enable_debug_outputs,
  output logic                       passthrough,
  output logic [2:0]                 vetopmtlast,
  output logic                       useInternalTestPulse,
  output logic                       useExternalTestPulse,
  output logic [NUM_PLL*8-1:0]       pll_shifts,
  output logic                       updatepll,
  output logic                       cmd_error,
  output logic                       busy
);

  localparam int NBYTES = NUM_HIST * HIST_W / 8;
  localparam int AIW    = $clog2(NUM_PLL + 1);
  localparam int BIW    = $clog2(NBYTES + 1);
  localparam int TOW    = $clog2(ARG_TIMEOUT + 1);

  localparam logic [3:0] OP_VERSION   = 4'd0;
  localparam logic [3:0] OP_SET_OUT   = 4'd1;
  localparam logic [3:0] OP_SET_PLL   = 4'd2;
  localparam logic [3:0] OP_SET_PASS  = 4'd3;
  localparam logic [3:0] OP_SEND_HIST = 4'd4;
  localparam logic [3:0] OP_SET_VETO  = 4'd5;
  localparam logic [3:0] OP_RESET_PLL = 4'd6;
  localparam logic [3:0] OP_SET_TEST  = 4'd7;
  localparam logic [3:0] OP_STATUS    = 4'd8;
  localparam logic [3:0] OP_CLR_ERR   = 4'd9;

  typedef enum logic [2:0] {
    IDLE, ARGS, EXEC, TX_LOAD, TX_HOLD, TX_WAIT, PLLUPD
  } state_e;

  state_e                      r_state;
  logic [3:0]                  r_opcode;
  logic [AIW-1:0]              r_nargs;
  logic [AIW-1:0]              r_arg_idx;
  logic [NUM_PLL*8-1:0]        r_args;
  logic [TOW-1:0]              r_to;
  logic [NUM_HIST*HIST_W-1:0]  r_snap;
  logic [BIW-1:0]              r_byte_idx;
  logic                        r_is_hist;
  logic [7:0]                  r_reply;
  logic [AIW-1:0]              w_nargs_rx;

  function automatic logic [AIW-1:0] f_nargs(input logic [3:0] op);
    case (op)
      OP_SET_OUT, OP_SET_PASS, OP_SET_VETO, OP_SET_TEST: f_nargs = AIW'(1);
      OP_SET_PLL:                                        f_nargs = AIW'(NUM_PLL);
      default:                                           f_nargs = '0;
    endcase
  endfunction

  assign w_nargs_rx = f_nargs(rxData[3:0]);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state              <= IDLE;
      r_opcode             <= '0;
      r_nargs              <= '0;
      r_arg_idx            <= '0;
      r_args               <= '0;
      r_to                 <= '0;
      r_snap               <= '0;
      r_byte_idx           <= '0;
      r_is_hist            <= 1'b0;
      r_reply              <= '0;
      txStart              <= 1'b0;
      txData               <= '0;
      resethist            <= 1'b0;
      disable_line_drivers <= 1'b0;
      enable_debug_outputs <= 1'b0;
      passthrough          <= 1'b0;
      vetopmtlast          <= 3'b001;
      useInternalTestPulse <= 1'b0;
      useExternalTestPulse <= 1'b0;
      pll_shifts           <= '0;
      updatepll            <= 1'b0;
      cmd_error            <= 1'b0;
    end else begin
      txStart   <= 1'b0;
      resethist <= 1'b0;
      updatepll <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rxReady) begin
            r_arg_idx <= '0;
            r_to      <= '0;
            if (rxData > 8'd9) begin
              // Unknown opcode: NAK and flag, no decode.
              cmd_error <= 1'b1;
              r_reply   <= 8'hFF;
              r_is_hist <= 1'b0;
              r_state   <= TX_LOAD;
            end else begin
              r_opcode <= rxData[3:0];
              r_nargs  <= w_nargs_rx;
              r_state  <= (w_nargs_rx == '0) ? EXEC : ARGS;
            end
          end
        end
        ARGS: begin
          if (rxReady) begin
            r_args[{r_arg_idx, 3'b000} +: 8] <= rxData;
            r_arg_idx <= r_arg_idx + 1'b1;
            r_to      <= '0;
            if (r_arg_idx == r_nargs - 1'b1) r_state <= EXEC;
          end else if (r_to == TOW'(ARG_TIMEOUT - 1)) begin
            // Abandon the command; nothing collected so far is applied.
            cmd_error <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        EXEC: begin
          r_state    <= IDLE;
          r_is_hist  <= 1'b0;
          r_byte_idx <= '0;
          case (r_opcode)
            OP_VERSION: begin
              r_reply <= FW_VERSION;
              r_state <= TX_LOAD;
            end
            OP_SET_OUT: begin
              disable_line_drivers <= ~r_args[0];
              enable_debug_outputs <= r_args[1];
            end
            OP_SET_PLL: begin
              pll_shifts <= r_args;
              r_state    <= PLLUPD;
            end
            OP_SET_PASS:  passthrough <= (r_args[7:0] != 8'd0);
            OP_SEND_HIST: begin
              r_snap    <= h_in;
              resethist <= 1'b1;
              r_is_hist <= 1'b1;
              r_state   <= TX_LOAD;
            end
            OP_SET_VETO:  vetopmtlast <= r_args[2:0];
            OP_RESET_PLL: begin
              pll_shifts <= '0;
              r_state    <= PLLUPD;
            end
            OP_SET_TEST: begin
              useInternalTestPulse <= r_args[0];
              useExternalTestPulse <= r_args[1];
            end
            OP_STATUS: begin
              r_reply <= {6'b0, passthrough, cmd_error};
              r_state <= TX_LOAD;
            end
            OP_CLR_ERR:   cmd_error <= 1'b0;
            default: ;
          endcase
        end
        TX_LOAD: begin
          if (!txBusy) begin
            txData  <= r_is_hist ? r_snap[{r_byte_idx, 3'b000} +: 8] : r_reply;
            txStart <= 1'b1;
            r_state <= TX_HOLD;
          end
        end
        // One dead cycle so the UART has time to raise txBusy.
        TX_HOLD: r_state <= TX_WAIT;
        TX_WAIT: begin
          if (!txBusy) begin
            if (r_is_hist && (r_byte_idx != BIW'(NBYTES - 1))) begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= TX_LOAD;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        PLLUPD: begin
          updatepll <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmd_engine.sv
// tb/tb_serial_cmd_engine.sv - directed self-checking bench for serial_cmd_engine
module tb_serial_cmd_engine;

  localparam int NUM_HIST = 10;
  localparam int HIST_W   = 32;
  localparam int NUM_PLL  = 6;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       rxReady;
  logic [7:0]                 rxData;
  logic                       txBusy;
  logic                       txStart;
  logic [7:0]                 txData;
  logic [NUM_HIST*HIST_W-1:0] h_in;
  logic                       resethist;
  logic                       disable_line_drivers;
  logic                       enable_debug_outputs;
  logic                       passthrough;
  logic [2:0]                 vetopmtlast;
  logic                       useInternalTestPulse;
  logic                       useExternalTestPulse;
  logic [NUM_PLL*8-1:0]       pll_shifts;
  logic                       updatepll;
  logic                       cmd_error;
  logic                       busy;

  int         n_total = 0;
  int         n_bad   = 0;
  int         n_tx    = 0;
  int         n_rh    = 0;
  int         n_up    = 0;
  int         busy_cnt = 0;
  logic [7:0] txq[$];
  logic [31:0] hv[NUM_HIST];

  always #5 clk = ~clk;

  serial_cmd_engine #(
    .NUM_HIST(NUM_HIST), .HIST_W(HIST_W), .NUM_PLL(NUM_PLL),
    .FW_VERSION(8'd24), .ARG_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .rxReady(rxReady), .rxData(rxData),
    .txBusy(txBusy), .txStart(txStart), .txData(txData), .h_in(h_in),
    .resethist(resethist), .disable_line_drivers(disable_line_drivers),
    .enable_debug_outputs(enable_debug_outputs), .passthrough(passthrough),
    .vetopmtlast(vetopmtlast), .useInternalTestPulse(useInternalTestPulse),
    .useExternalTestPulse(useExternalTestPulse), .pll_shifts(pll_shifts),
    .updatepll(updatepll), .cmd_error(cmd_error), .busy(busy)
  );

  // UART transmitter model: captures bytes and stays busy 4 cycles per byte.
  initial begin
    txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) busy_cnt = 0;
      else if (txStart) begin
        txq.push_back(txData);
        n_tx++;
        busy_cnt = 4;
      end
      if (resethist) n_rh++;
      if (updatepll) n_up++;
      txBusy = (busy_cnt != 0);
      if (busy_cnt != 0) busy_cnt--;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("idle", 64'(busy), 64'd0);
  endtask

  task automatic cmd1(input logic [7:0] op, input logic [7:0] arg);
    send_byte(op);
    send_byte(arg);
    wait_idle();
  endtask

  task automatic reply_test(input logic [7:0] op, input logic [7:0] exp, input string tag);
    int b = n_tx;
    send_byte(op);
    wait_idle();
    chk({tag, "_cnt"}, 64'(n_tx - b), 64'd1);
    if (n_tx > b) chk(tag, 64'(txq[txq.size() - 1]), 64'(exp));
  endtask

  initial begin
    int b;
    int brh;
    int bup;
    int mis;
    int seen;
    logic [7:0] pll_arg[NUM_PLL];

    reset = 1'b1; rxReady = 1'b0; rxData = 8'd0; h_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_veto", 64'(vetopmtlast), 64'd1);
    chk("rst_ctrl", 64'({txStart, resethist, disable_line_drivers, enable_debug_outputs,
                         passthrough, useInternalTestPulse, useExternalTestPulse,
                         updatepll, cmd_error, busy}), 64'd0);
    chk("rst_pll", 64'(pll_shifts), 64'd0);

    reply_test(8'h00, 8'd24, "version");

    // SET_PLL and update pulse timing
    pll_arg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bup = n_up;
    send_byte(8'h02);
    foreach (pll_arg[j]) send_byte(pll_arg[j]);
    @(negedge clk); chk("upd_t1", 64'(updatepll), 64'd0);
    @(negedge clk); chk("upd_t2", 64'(updatepll), 64'd1);
    @(negedge clk); chk("upd_t3", 64'(updatepll), 64'd0);
    wait_idle();
    chk("pll_set", 64'(pll_shifts), 64'h665544332211);
    chk("upd_cnt", 64'(n_up - bup), 64'd1);
    send_byte(8'h06);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("pll_clr", 64'(pll_shifts), 64'd0);
    chk("upd_cnt2", 64'(n_up - bup), 64'd2);

    // Write-only control commands
    b = n_tx;
    cmd1(8'h01, 8'h02);
    chk("out_a", 64'({disable_line_drivers, enable_debug_outputs}), 64'b11);
    cmd1(8'h01, 8'h01);
    chk("out_b", 64'({disable_line_drivers, enable_debug_outputs}), 64'b00);
    cmd1(8'h03, 8'h80);
    chk("pass_on", 64'(passthrough), 64'd1);
    cmd1(8'h03, 8'h00);
    chk("pass_off", 64'(passthrough), 64'd0);
    cmd1(8'h07, 8'h02);
    chk("test_in", 64'({useInternalTestPulse, useExternalTestPulse}), 64'b01);
    cmd1(8'h05, 8'h06);
    chk("veto", 64'(vetopmtlast), 64'd6);
    chk("wo_noreply", 64'(n_tx - b), 64'd0);

    // Histogram snapshot and stream
    for (int k = 0; k < NUM_HIST; k++)
      hv[k] = {8'(k + 8'h30), 8'(k + 8'h20), 8'(k + 8'h10), 8'(k)};
    hv[0] = 32'h04030201;
    hv[NUM_HIST-1] = 32'hDEADBEEF;
    for (int k = 0; k < NUM_HIST; k++) h_in[k*HIST_W +: HIST_W] = hv[k];
    b = n_tx; brh = n_rh;
    send_byte(8'h04);
    @(negedge clk);
    h_in = '1;
    wait_idle();
    chk("hist_cnt", 64'(n_tx - b), 64'd40);
    chk("hist_first", 64'({txq[b], txq[b+1], txq[b+2], txq[b+3]}), 64'h01020304);
    chk("hist_last", 64'({txq[b+36], txq[b+37], txq[b+38], txq[b+39]}), 64'hEFBEADDE);
    mis = 0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = hv[i/4];
      if (txq[b+i] !== w[(i%4)*8 +: 8]) mis++;
    end
    chk("hist_all", 64'(mis), 64'd0);
    chk("resethist", 64'(n_rh - brh), 64'd1);

    // Bad opcode, status, clear error
    reply_test(8'h3A, 8'hFF, "bad_op");
    chk("err_set", 64'(cmd_error), 64'd1);
    reply_test(8'h08, 8'h01, "status1");
    send_byte(8'h09);
    wait_idle();
    chk("err_clr", 64'(cmd_error), 64'd0);
    reply_test(8'h08, 8'h00, "status0");

    // Argument arriving on the last cycle before timeout is accepted
    send_byte(8'h05);
    repeat (97) @(negedge clk);
    send_byte(8'h03);
    wait_idle();
    chk("to_edge_veto", 64'(vetopmtlast), 64'd3);
    chk("to_edge_err", 64'(cmd_error), 64'd0);

    // Argument timeout
    send_byte(8'h05);
    repeat (98) @(negedge clk);
    chk("to_pending", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_veto", 64'(vetopmtlast), 64'd3);
    chk("to_err", 64'(cmd_error), 64'd1);

    // Reset during the fifth histogram byte
    cmd1(8'h03, 8'h01);
    cmd1(8'h05, 8'h06);
    b = n_tx;
    send_byte(8'h04);
    for (int i = 0; i < 500 && n_tx < b + 5; i++) @(negedge clk);
    chk("mid_bytes", 64'(n_tx - b), 64'd5);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txStart || busy) seen++;
    end
    chk("mid_quiet", 64'(seen), 64'd0);
    chk("mid_count", 64'(n_tx - b), 64'd5);
    chk("mid_veto", 64'(vetopmtlast), 64'd1);
    chk("mid_ctrl", 64'({passthrough, cmd_error, disable_line_drivers, enable_debug_outputs,
                         useInternalTestPulse, useExternalTestPulse, updatepll, resethist}), 64'd0);
    chk("mid_pll", 64'(pll_shifts), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
